// File: rtl/camera_core.sv
// ---------------------------------------------------------------------------
// camera_core -- synthetic frame capture engine with a byte-read command port.
//
// A 0x20 command fills an internal frame buffer at one byte per clock with a
// ramp pattern offset by a frame counter. 0x21 reports how many unread bytes
// are waiting (saturated at 255). 0x22 pops one byte per operand.
//
// Optional feature (macro CAMERA_CORE_CHECKSUM_EN): keeps a running XOR of
// every byte popped by 0x22 since the last capture start. Opcode 0x23 returns
// that value. Without the macro, 0x23 is treated as an unknown opcode.
//
// Ports:
//   clock_spi_in        single clock, rising edge
//   reset_spi_n_in      asynchronous active-low reset
//   op_code_in[7:0]     command opcode, held for the whole transaction
//   op_code_valid_in    high for the duration of a transaction
//   operand_in[7:0]     operand byte (content unused)
//   operand_valid_in    one pulse (any length) per operand byte
//   operand_count_in    1-based operand index (informational, unused)
//   response_out[7:0]   registered response byte
//   response_valid_out  high from the first response until the transaction ends
// ---------------------------------------------------------------------------
module camera_core #(
   parameter int CAPTURE_X_RESOLUTION = 16,
   parameter int CAPTURE_Y_RESOLUTION = 16
) (
   input  logic        clock_spi_in,
   input  logic        reset_spi_n_in,
   input  logic [7:0]  op_code_in,
   input  logic        op_code_valid_in,
   input  logic [7:0]  operand_in,
   input  logic        operand_valid_in,
   input  logic [31:0] operand_count_in,
   output logic [7:0]  response_out,
   output logic        response_valid_out
);

   localparam int FRAME_BYTES = CAPTURE_X_RESOLUTION * CAPTURE_Y_RESOLUTION;
   // Pointers must be able to hold FRAME_BYTES itself (full / fully written).
   localparam int PTR_W     = $clog2(FRAME_BYTES + 1);
   localparam int IDX_W     = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam int MEM_DEPTH = 1 << IDX_W;

   localparam logic [7:0] OP_CAPTURE = 8'h20;
   localparam logic [7:0] OP_AVAIL   = 8'h21;
   localparam logic [7:0] OP_READ    = 8'h22;
   localparam logic [7:0] OP_CSUM    = 8'h23;

   typedef enum logic {IDLE, CAPTURE} state_t;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [7:0]       fc_q, fc_d;
   logic [7:0]       resp_q, resp_d;
   logic             resp_vld_q, resp_vld_d;
   logic             op_vld_q, opnd_vld_q;
`ifdef CAMERA_CORE_CHECKSUM_EN
   logic [7:0]       cs_q, cs_d;
`endif

   // Frame storage: intentionally not reset; stale data is unreachable
   // because reset zeroes both pointers.
   logic [7:0] buf_mem [0:MEM_DEPTH-1];

   logic             op_evt, opnd_evt, resp_set;
   logic             wr_en;
   logic [7:0]       wr_data, rd_data;
   logic [PTR_W-1:0] avail;

   // Operand count and operand byte carry no information for any opcode.
   logic unused_ok;
   assign unused_ok = ^{operand_in, operand_count_in};

   assign op_evt   = op_code_valid_in & ~op_vld_q;
   assign opnd_evt = operand_valid_in & ~opnd_vld_q & op_code_valid_in;
   assign avail    = wr_q - rd_q;
   assign wr_data  = 8'(wr_q) + fc_q;
   assign rd_data  = buf_mem[IDX_W'(rd_q)];

   always_comb begin
      state_d  = state_q;
      wr_d     = wr_q;
      rd_d     = rd_q;
      fc_d     = fc_q;
      resp_d   = resp_q;
      resp_set = 1'b0;
      wr_en    = 1'b0;
`ifdef CAMERA_CORE_CHECKSUM_EN
      cs_d     = cs_q;
`endif

      if (state_q == CAPTURE) begin
         wr_en = 1'b1;
         wr_d  = wr_q + PTR_W'(1);
         if (wr_q == PTR_W'(FRAME_BYTES - 1)) begin
            state_d = IDLE;
            fc_d    = fc_q + 8'd1;
         end
      end

      // A capture request while already capturing falls through untouched.
      if (op_evt && (op_code_in == OP_CAPTURE) && (state_q == IDLE)) begin
         state_d = CAPTURE;
         wr_d    = '0;
         rd_d    = '0;
`ifdef CAMERA_CORE_CHECKSUM_EN
         cs_d    = 8'h00;
`endif
      end

      if (opnd_evt) begin
         case (op_code_in)
            OP_CAPTURE: ;
            OP_AVAIL: begin
               resp_d   = (32'(avail) > 32'd255) ? 8'hFF : 8'(avail);
               resp_set = 1'b1;
            end
            OP_READ: begin
               resp_set = 1'b1;
               if (avail != '0) begin
                  resp_d = rd_data;
                  rd_d   = rd_q + PTR_W'(1);
`ifdef CAMERA_CORE_CHECKSUM_EN
                  cs_d   = cs_q ^ rd_data;
`endif
               end else begin
                  resp_d = 8'h00;
               end
            end
`ifdef CAMERA_CORE_CHECKSUM_EN
            OP_CSUM: begin
               resp_d   = cs_q;
               resp_set = 1'b1;
            end
`endif
            default: resp_d = 8'h00;
         endcase
      end

      // Sticky for the rest of the transaction, dropped as soon as it ends.
      resp_vld_d = op_code_valid_in & (resp_vld_q | resp_set);
   end

   always_ff @(posedge clock_spi_in or negedge reset_spi_n_in) begin
      if (!reset_spi_n_in) begin
         state_q    <= IDLE;
         wr_q       <= '0;
         rd_q       <= '0;
         fc_q       <= 8'h00;
         resp_q     <= 8'h00;
         resp_vld_q <= 1'b0;
         op_vld_q   <= 1'b0;
         opnd_vld_q <= 1'b0;
`ifdef CAMERA_CORE_CHECKSUM_EN
         cs_q       <= 8'h00;
`endif
      end else begin
         state_q    <= state_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         fc_q       <= fc_d;
         resp_q     <= resp_d;
         resp_vld_q <= resp_vld_d;
         op_vld_q   <= op_code_valid_in;
         opnd_vld_q <= operand_valid_in;
`ifdef CAMERA_CORE_CHECKSUM_EN
         cs_q       <= cs_d;
`endif
      end
   end

   always_ff @(posedge clock_spi_in) begin
      if (wr_en) buf_mem[IDX_W'(wr_q)] <= wr_data;
   end

   assign response_out       = resp_q;
   assign response_valid_out = resp_vld_q;

endmodule

// File: tb/tb_camera_core.sv
// ---------------------------------------------------------------------------
// tb_camera_core -- directed bench for camera_core at X=Y=5 (25-byte frame).
// A small reference model (byte queue, frame counter, XOR) computes each
// expected response when an operand is driven; the expectation is queued and
// popped when the registered response appears one clock later.
// ---------------------------------------------------------------------------
module tb_camera_core;

   localparam int XR = 5;
   localparam int YR = 5;
   localparam int FB = XR * YR;

   typedef struct packed {
      logic [7:0] val;
      logic       vld;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  op_code = 8'h00;
   logic        op_valid = 1'b0;
   logic [7:0]  operand = 8'h00;
   logic        operand_valid = 1'b0;
   logic [31:0] operand_count = 32'd0;
   logic [7:0]  resp;
   logic        resp_valid;

   int   tests = 0;
   int   fails = 0;
   rsp_t sb_q[$];
   logic [7:0] mq[$];
   logic [7:0] mfc = 8'h00;
   logic [7:0] mcs = 8'h00;
   logic [7:0] last_resp = 8'h00;

   camera_core #(
      .CAPTURE_X_RESOLUTION(XR),
      .CAPTURE_Y_RESOLUTION(YR)
   ) dut (
      .clock_spi_in      (clk),
      .reset_spi_n_in    (rst_n),
      .op_code_in        (op_code),
      .op_code_valid_in  (op_valid),
      .operand_in        (operand),
      .operand_valid_in  (operand_valid),
      .operand_count_in  (operand_count),
      .response_out      (resp),
      .response_valid_out(resp_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   function automatic rsp_t model_rsp(input logic [7:0] op);
      rsp_t r;
      r.val = 8'h00;
      r.vld = 1'b0;
      case (op)
         8'h21: begin
            r.val = (mq.size() > 255) ? 8'hFF : 8'(mq.size());
            r.vld = 1'b1;
         end
         8'h22: begin
            r.vld = 1'b1;
            if (mq.size() > 0) begin
               r.val = mq.pop_front();
               mcs   = mcs ^ r.val;
            end
         end
`ifdef CAMERA_CORE_CHECKSUM_EN
         8'h23: begin
            r.val = mcs;
            r.vld = 1'b1;
         end
`endif
         8'h20: r.val = last_resp;
         default: ;
      endcase
      return r;
   endfunction

   task automatic model_capture();
      mq.delete();
      for (int k = 0; k < FB; k++) mq.push_back(8'(k) + mfc);
      mfc = mfc + 8'd1;
      mcs = 8'h00;
   endtask

   task automatic model_reset();
      mq.delete();
      mfc = 8'h00;
      mcs = 8'h00;
      last_resp = 8'h00;
   endtask

   // One transaction: n operands, each held high for hold cycles.
   task automatic send_op(input logic [7:0] op, input int n, input int hold, input string tag);
      rsp_t e;
      op_code  = op;
      op_valid = 1'b1;
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         operand_valid = 1'b1;
         operand_count = 32'(i + 1);
         operand       = 8'($urandom_range(0, 255));
         sb_q.push_back(model_rsp(op));
         repeat (hold) @(negedge clk);
         e = sb_q.pop_front();
         chk($sformatf("%s op%02h#%0d data", tag, op, i), resp, e.val);
         chk($sformatf("%s op%02h#%0d vld", tag, op, i), {7'd0, resp_valid}, {7'd0, e.vld});
         last_resp = e.val;
         operand_valid = 1'b0;
         @(negedge clk);
      end
      op_valid      = 1'b0;
      operand_count = 32'd0;
      @(negedge clk);
      chk($sformatf("%s op%02h end vld", tag, op), {7'd0, resp_valid}, 8'h00);
      chk($sformatf("%s op%02h end hold", tag, op), resp, last_resp);
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset resp", resp, 8'h00);
      chk("reset vld", {7'd0, resp_valid}, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // First frame, fc = 0
      send_op(8'h20, 0, 1, "cap1");
      model_capture();
      repeat (30) @(negedge clk);
      send_op(8'h21, 1, 1, "avail25");
      send_op(8'h22, 10, 1, "rd10");
      send_op(8'h21, 1, 1, "avail15");
      send_op(8'h22, 9, 1, "rd9");
      send_op(8'h21, 1, 1, "avail6");
      send_op(8'h22, 3, 1, "rd3");
      send_op(8'h21, 1, 1, "avail3");
      send_op(8'h22, 3, 3, "drain_hold");
      send_op(8'h22, 2, 1, "empty");
      send_op(8'h21, 1, 1, "avail0");
      send_op(8'h55, 1, 1, "unknown");

      // Second frame, fc = 1: reads overlap generation, re-capture is ignored
      send_op(8'h20, 0, 1, "cap2");
      model_capture();
      @(negedge clk);
      send_op(8'h22, 2, 1, "overlap");
      send_op(8'h20, 0, 1, "cap_ignored");
      repeat (30) @(negedge clk);
      send_op(8'h21, 1, 1, "avail23");

      // Third frame, fc = 2: checksum over ten reads
      send_op(8'h20, 0, 1, "cap3");
      model_capture();
      repeat (30) @(negedge clk);
      send_op(8'h22, 10, 1, "cs_rd");
      send_op(8'h23, 1, 1, "csum");

      // Reset about ten clocks into a capture
      send_op(8'h20, 0, 1, "cap4");
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("inreset resp", resp, 8'h00);
      chk("inreset vld", {7'd0, resp_valid}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      send_op(8'h21, 1, 1, "post_rst_avail");
      send_op(8'h22, 1, 1, "post_rst_rd");

      // Frame counter restarts at 0 after reset
      send_op(8'h20, 0, 1, "cap5");
      model_capture();
      repeat (30) @(negedge clk);
      send_op(8'h22, 3, 2, "fc_restart");
      send_op(8'h21, 1, 1, "avail22");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/camera_core.md
CAMERA_CORE -- requirements
Module: camera_core

Interface
REQ-001 Parameter CAPTURE_X_RESOLUTION, default 16, frame width in pixels (1..64).
REQ-002 Parameter CAPTURE_Y_RESOLUTION, default 16, frame height in pixels (1..64); one byte per pixel, FRAME_BYTES = X*Y.
REQ-003 clock_spi_in  input  1  single clock; one clock; all logic on rising edge.
REQ-004 reset_spi_n_in  input  1  reset is asynchronous and active-low.
REQ-005 op_code_in  input  8  command opcode.
REQ-006 op_code_valid_in  input  1  high for the whole transaction; low between transactions.
REQ-007 operand_in  input  8  operand byte (value ignored by all opcodes).
REQ-008 operand_valid_in  input  1  high for each operand byte, low between bytes.
REQ-009 operand_count_in  input  32  1-based index of current operand; 0 between transactions.
REQ-010 response_out  output  8  response byte.
REQ-011 response_valid_out  output  1  response_out holds a valid byte.

Function
REQ-012 Inputs are level-sampled; "opcode event" = op_code_valid_in rising edge; "operand event" = operand_valid_in rising edge while op_code_valid_in high.
REQ-013 Internal frame buffer of FRAME_BYTES bytes; write pointer wr, read pointer rd, frame counter fc (8 bits).
REQ-014 States: IDLE, CAPTURE; CAPTURE entered on opcode event with op_code_in 0x20 from IDLE.
REQ-015 Entering CAPTURE: wr=0, rd=0, discarding unread data; one byte per clock written, byte k = (k + fc) mod 256.
REQ-016 When wr reaches FRAME_BYTES: return to IDLE, fc increments (wraps 0xFF->0x00).
REQ-017 Opcode 0x20 received in CAPTURE is ignored; capture continues unaffected.
REQ-018 available = wr - rd; valid during CAPTURE (reads may overlap generation).
REQ-019 Opcode 0x21, operand event: response_out = min(available, 255), registered one clock after the event.
REQ-020 Opcode 0x22, operand event: response_out = buffer[rd] and rd increments, one clock latency; if available = 0, response_out = 0x00, rd unchanged.
REQ-021 Exactly one byte consumed per operand event regardless of operand_valid_in high duration.
REQ-022 response_valid_out = 1 from first response of a 0x21/0x22/0x23 transaction until op_code_valid_in falls; otherwise 0.
REQ-023 Unknown opcodes: no state change, response_out 0x00, response_valid_out 0.
REQ-024 response_out keeps last value between operand events and after transaction end.

Reset
REQ-025 Asserted reset immediately forces: state IDLE, wr=0, rd=0, fc=0, checksum=0, response_out=0x00, response_valid_out=0, edge detectors cleared.
REQ-026 Reset mid-capture abandons the frame; after release, available = 0 until a new 0x20.
REQ-027 Buffer contents not cleared by reset; unreachable until rewritten.

Configuration
REQ-028 Macro CAMERA_CORE_CHECKSUM_EN defined: 8-bit XOR of every byte returned by 0x22 since last capture start is kept; opcode 0x23 operand event returns it; capture start and reset clear it.
REQ-029 Macro not defined: no checksum logic; 0x23 treated as unknown opcode (REQ-023).

Verification (X=Y=5, FRAME_BYTES=25)
REQ-030 Reset release, 0x20, wait 30 clocks, 0x21 one operand -> response 0x19, response_valid_out 1 until op_code_valid_in falls.
REQ-031 Then 0x22 with 10 operands -> 0x00..0x09; 0x21 -> 0x0F; 0x22 ×9 -> 0x0A..0x12; 0x21 -> 0x06; 0x22 ×3 -> 0x13..0x15; 0x21 -> 0x03.
REQ-032 Drain remaining 3, then 0x22 ×2 -> 0x00, 0x00; 0x21 -> 0x00.
REQ-033 Second 0x20, wait 30 clocks, 0x22 ×2 -> 0x01, 0x02 (fc=1); 0x20 sent mid-capture ignored.
REQ-034 With CAMERA_CORE_CHECKSUM_EN: after fresh capture, read 10 bytes, 0x23 -> 0x01; without macro -> 0x00, response_valid_out 0.
REQ-035 Assert reset 10 clocks into capture, release, 0x21 -> 0x00; all outputs 0 during reset.
